// File: rtl/tc_counter_pkg.sv
// rtl/tc_counter_pkg.sv - overflow-mode encoding shared by the multimode counter files
package tc_counter_pkg;

  typedef enum logic [1:0] {
    MODE_WRAP    = 2'd0,
    MODE_SAT     = 2'd1,
    MODE_ONESHOT = 2'd2
  } mode_e;

  // Reserved encoding 3 falls through to wrap behaviour.
  function automatic logic is_sat_mode(input logic [1:0] mode);
    return (mode == MODE_SAT) || (mode == MODE_ONESHOT);
  endfunction

endpackage

// File: rtl/tc_counter_next.sv
// rtl/tc_counter_next.sv - combinational next-count and bound-hit calculation
module tc_counter_next
  import tc_counter_pkg::*;
#(
  parameter int BIT_WIDTH = 8
) (
  input  logic [BIT_WIDTH-1:0] out,
  input  logic [BIT_WIDTH-1:0] step,
  input  logic [BIT_WIDTH-1:0] limit,
  input  logic                 dir,
  input  logic [1:0]           mode,
  output logic [BIT_WIDTH-1:0] next_out,
  output logic                 hit_bound
);

  localparam logic [BIT_WIDTH:0]   ONE_X = (BIT_WIDTH+1)'(1);
  localparam logic [BIT_WIDTH-1:0] ONE_W = BIT_WIDTH'(1);

  logic [BIT_WIDTH:0]   cur;
  logic [BIT_WIDTH:0]   inc;
  logic [BIT_WIDTH:0]   lim;
  logic [BIT_WIDTH:0]   lim_p1;
  logic [BIT_WIDTH:0]   sum;
  logic [BIT_WIDTH:0]   deficit;
  logic [BIT_WIDTH:0]   wrapped_up;
  logic [BIT_WIDTH-1:0] diff;
  logic [BIT_WIDTH-1:0] wrapped_dn;

  assign cur        = {1'b0, out};
  assign inc        = {1'b0, step};
  assign lim        = {1'b0, limit};
  assign lim_p1     = lim + ONE_X;
  assign sum        = cur + inc;
  assign deficit    = inc - cur;
  assign wrapped_up = sum - lim_p1;
  assign diff       = out - step;
  // limit+1-(step-out); only used when the exact result fits, so modulo wrap is harmless.
  assign wrapped_dn = limit + out - step + ONE_W;

  always_comb begin
    next_out  = out;
    hit_bound = 1'b0;
    if (step != '0) begin
      if (is_sat_mode(mode)) begin
        if (!dir) begin
          if (sum >= lim) begin
            next_out  = limit;
            hit_bound = (cur != lim);
          end else begin
            next_out = sum[BIT_WIDTH-1:0];
          end
        end else begin
          if (cur <= inc) begin
            next_out  = '0;
            hit_bound = (out != '0);
          end else begin
            next_out = diff;
          end
        end
      end else if (!dir) begin
        if (sum > lim) begin
          hit_bound = 1'b1;
          next_out  = (wrapped_up > lim) ? '0 : wrapped_up[BIT_WIDTH-1:0];
        end else begin
          next_out = sum[BIT_WIDTH-1:0];
        end
      end else begin
        if (cur < inc) begin
          hit_bound = 1'b1;
          next_out  = (deficit > lim_p1) ? limit : wrapped_dn;
        end else begin
          next_out = diff;
        end
      end
    end
  end

endmodule

// File: rtl/tc_multimode_counter.sv
// rtl/tc_multimode_counter.sv - up/down counter with wrap/saturate/one-shot modes and tc pulse
// Optional compare output enabled by defining TC_COUNTER_CMP_EN.
module tc_multimode_counter
  import tc_counter_pkg::*;
#(
  parameter int                   BIT_WIDTH   = 8,
  parameter logic [BIT_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 load,
  input  logic [BIT_WIDTH-1:0] load_val,
  input  logic                 dir,
  input  logic [BIT_WIDTH-1:0] step,
  input  logic [BIT_WIDTH-1:0] limit,
  input  logic [1:0]           mode,
`ifdef TC_COUNTER_CMP_EN
  input  logic [BIT_WIDTH-1:0] cmp_val,
  output logic                 cmp_match,
`endif
  output logic [BIT_WIDTH-1:0] out,
  output logic                 tc,
  output logic                 done
);

  logic [BIT_WIDTH-1:0] next_out;
  logic                 hit_bound;
  logic [BIT_WIDTH-1:0] out_d;
  logic                 tc_d;
  logic                 done_d;

  tc_counter_next #(
    .BIT_WIDTH(BIT_WIDTH)
  ) u_next (
    .out      (out),
    .step     (step),
    .limit    (limit),
    .dir      (dir),
    .mode     (mode),
    .next_out (next_out),
    .hit_bound(hit_bound)
  );

  // Load beats counting; a finished one-shot stays frozen until reloaded.
  always_comb begin
    out_d  = out;
    tc_d   = 1'b0;
    done_d = done;
    if (load) begin
      out_d  = load_val;
      done_d = 1'b0;
    end else if (en && !done) begin
      out_d = next_out;
      tc_d  = hit_bound;
      if ((mode == MODE_ONESHOT) && hit_bound) begin
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out  <= RESET_VALUE;
      tc   <= 1'b0;
      done <= 1'b0;
    end else begin
      out  <= out_d;
      tc   <= tc_d;
      done <= done_d;
    end
  end

`ifdef TC_COUNTER_CMP_EN
  // Compared against the value being registered so the flag lines up with out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmp_match <= 1'b0;
    end else begin
      cmp_match <= (out_d == cmp_val);
    end
  end
`else
  // Without the compare feature out, tc and done are the only state.
`endif

endmodule
